btb_predictor: RTL and testbench

BTB_PREDICTOR -- requirements
Module: btb_predictor

---
 rtl/btb_predictor.sv | 133 +++++++++++++
 tb/tb_btb_predictor.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/btb_predictor.sv
// Branch target buffer with bimodal or gshare indexing.
// Valid bits are cleared by a one-entry-per-cycle walk after reset or invalidate.
module btb_predictor #(
  parameter int ENTRIES  = 16,
  parameter int TAG_W    = 8,
  parameter int CTR_BITS = 2,
  parameter int MODE     = 0,
  parameter int HIST_W   = $clog2(ENTRIES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 lookup_pc,
  output logic                        lookup_hit,
  output logic                        lookup_taken,
  output logic [31:0]                 lookup_target,
  output logic [$clog2(ENTRIES)-1:0]  lookup_idx,
  input  logic                        upd_valid,
  input  logic [31:0]                 upd_pc,
  input  logic [$clog2(ENTRIES)-1:0]  upd_idx,
  input  logic                        upd_taken,
  input  logic [31:0]                 upd_target,
  input  logic                        upd_mispredict,
  input  logic                        inv_all,
  output logic                        ready,
  output logic [31:0]                 hit_cnt,
  output logic [31:0]                 mispred_cnt
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1 << (CTR_BITS - 1));

  typedef enum logic {INIT, RUN} state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   walk, walk_nx;
  logic [HIST_W-1:0]  ghr;
  logic [ENTRIES-1:0] valid;

  logic [TAG_W-1:0]    tag_q [ENTRIES];
  logic [31:0]         tgt_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q [ENTRIES];

  logic [TAG_W-1:0] l_tag, u_tag;
  logic [IDX_W-1:0] hist;
  logic             run, accept, u_hit;
  logic             unused;

  assign run   = (state == RUN);
  assign hist  = (MODE == 1) ? IDX_W'(ghr) : '0;
  assign l_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  assign lookup_idx    = lookup_pc[IDX_W+1:2] ^ hist;
  assign lookup_hit    = run && valid[lookup_idx]
                         && (tag_q[lookup_idx] == l_tag);
  assign lookup_taken  = lookup_hit && ctr_q[lookup_idx][CTR_BITS-1];
  assign lookup_target = lookup_hit ? tgt_q[lookup_idx] : '0;
  assign ready         = run;

  assign accept = upd_valid && rst_n && run;
  assign u_hit  = valid[upd_idx] && (tag_q[upd_idx] == u_tag);

  assign unused = ^{lookup_pc[31:IDX_W+TAG_W+2], lookup_pc[1:0],
                    upd_pc[31:IDX_W+TAG_W+2], upd_pc[1:0]};

  always_comb begin
    state_nx = state;
    walk_nx  = walk;
    unique case (state)
      INIT: begin
        if (inv_all) begin
          walk_nx = '0;
        end else if (walk == IDX_W'(ENTRIES - 1)) begin
          state_nx = RUN;
          walk_nx  = '0;
        end else begin
          walk_nx = walk + 1'b1;
        end
      end
      RUN: begin
        if (inv_all) begin
          state_nx = INIT;
          walk_nx  = '0;
        end
      end
      default: begin
        state_nx = INIT;
        walk_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= INIT;
      walk        <= '0;
      ghr         <= '0;
      hit_cnt     <= '0;
      mispred_cnt <= '0;
    end else begin
      state <= state_nx;
      walk  <= walk_nx;
      if (accept && MODE == 1)
        ghr <= HIST_W'({ghr, upd_taken});
      if (accept && u_hit && hit_cnt != 32'hFFFF_FFFF)
        hit_cnt <= hit_cnt + 32'd1;
      if (accept && upd_mispredict
          && mispred_cnt != 32'hFFFF_FFFF)
        mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

  // Payload storage is unreset; only valid bits gate its use.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      valid[walk] <= 1'b0;
    end else if (accept) begin
      if (u_hit) begin
        if (upd_taken) begin
          tgt_q[upd_idx] <= upd_target;
          if (ctr_q[upd_idx] != '1)
            ctr_q[upd_idx] <= ctr_q[upd_idx] + 1'b1;
        end else if (ctr_q[upd_idx] != '0) begin
          ctr_q[upd_idx] <= ctr_q[upd_idx] - 1'b1;
        end
      end else if (upd_taken) begin
        valid[upd_idx] <= 1'b1;
        tag_q[upd_idx] <= u_tag;
        tgt_q[upd_idx] <= upd_target;
        ctr_q[upd_idx] <= CTR_INIT;
      end
    end
  end
endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor: bimodal instance plus a gshare instance.
// Expected values are hand-derived constants.
module tb_btb_predictor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        lookup_hit, lookup_taken;
  logic [31:0] lookup_target;
  logic [3:0]  lookup_idx;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [3:0]  upd_idx = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_mispredict = 1'b0;
  logic        inv_all = 1'b0;
  logic        ready;
  logic [31:0] hit_cnt, mispred_cnt;

  logic [31:0] g_lookup_pc = '0;
  logic        g_hit, g_taken;
  logic [31:0] g_target;
  logic [3:0]  g_idx;
  logic        g_upd_valid = 1'b0;
  logic        g_upd_taken = 1'b0;
  logic        g_ready;
  logic [31:0] g_hit_cnt, g_mispred_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  btb_predictor #(.ENTRIES(16), .TAG_W(8), .CTR_BITS(2), .MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .lookup_pc(lookup_pc),
    .lookup_hit(lookup_hit), .lookup_taken(lookup_taken),
    .lookup_target(lookup_target), .lookup_idx(lookup_idx),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .inv_all(inv_all),
    .ready(ready), .hit_cnt(hit_cnt), .mispred_cnt(mispred_cnt)
  );

  btb_predictor #(.ENTRIES(16), .TAG_W(8), .CTR_BITS(2), .MODE(1)) dut_g (
    .clk(clk), .rst_n(rst_n), .lookup_pc(g_lookup_pc),
    .lookup_hit(g_hit), .lookup_taken(g_taken),
    .lookup_target(g_target), .lookup_idx(g_idx),
    .upd_valid(g_upd_valid), .upd_pc(32'h80), .upd_idx(4'd3),
    .upd_taken(g_upd_taken), .upd_target(32'h900),
    .upd_mispredict(1'b0), .inv_all(1'b0),
    .ready(g_ready), .hit_cnt(g_hit_cnt), .mispred_cnt(g_mispred_cnt)
  );

  task automatic do_upd(input logic [31:0] pc, input logic [3:0] idx,
                        input logic t, input logic [31:0] tgt,
                        input logic mp);
    @(negedge clk);
    upd_pc = pc; upd_idx = idx; upd_taken = t;
    upd_target = tgt; upd_mispredict = mp; upd_valid = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_pc = pc;
    #1;
  endtask

  task automatic test_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    lookup_pc = 32'h40;
    repeat (2) @(negedge clk);
    checks++; if (ready !== 1'b0) begin failures++;
      $display("FAIL %s_ready_in_reset got=%b exp=0", tag, ready); end
    checks++; if (hit_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin failures++;
      $display("FAIL %s_stats_cleared got=%0d/%0d exp=0/0", tag, hit_cnt, mispred_cnt); end
    rst_n = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      checks++; if (ready !== 1'b0 || lookup_hit !== 1'b0) begin failures++;
        $display("FAIL %s_init_cycle%0d ready=%b hit=%b exp=0,0", tag, k, ready, lookup_hit); end
    end
    @(negedge clk);
    checks++; if (ready !== 1'b1 || g_ready !== 1'b1) begin failures++;
      $display("FAIL %s_ready_rise got=%b/%b exp=1/1", tag, ready, g_ready); end
    look(32'h40);
    checks++; if (lookup_hit !== 1'b0 || lookup_target !== 32'd0) begin failures++;
      $display("FAIL %s_miss_after got=%b %h exp=0 0", tag, lookup_hit, lookup_target); end
  endtask

  task automatic test_alloc;
    do_upd(32'h40, 4'd0, 1'b1, 32'h100, 1'b1);
    look(32'h40);
    checks++; if ({lookup_hit, lookup_taken} !== 2'b11) begin failures++;
      $display("FAIL alloc_hit_taken got=%b%b exp=11", lookup_hit, lookup_taken); end
    checks++; if (lookup_target !== 32'h100 || lookup_idx !== 4'd0) begin failures++;
      $display("FAIL alloc_target got=%h idx=%0d exp=100 idx=0", lookup_target, lookup_idx); end
    checks++; if (hit_cnt !== 32'd0 || mispred_cnt !== 32'd1) begin failures++;
      $display("FAIL alloc_stats got=%0d/%0d exp=0/1", hit_cnt, mispred_cnt); end
  endtask

  task automatic test_counter;
    do_upd(32'h40, 4'd0, 1'b0, 32'h0, 1'b0);
    look(32'h40);
    checks++; if ({lookup_hit, lookup_taken} !== 2'b10 || lookup_target !== 32'h100) begin
      failures++;
      $display("FAIL ctr_dec1 got=%b%b %h exp=10 100", lookup_hit, lookup_taken, lookup_target); end
    repeat (3) do_upd(32'h40, 4'd0, 1'b0, 32'h0, 1'b0);
    look(32'h40);
    checks++; if (lookup_taken !== 1'b0 || hit_cnt !== 32'd4) begin failures++;
      $display("FAIL ctr_floor got taken=%b hit_cnt=%0d exp=0 4", lookup_taken, hit_cnt); end
    do_upd(32'h40, 4'd0, 1'b1, 32'h200, 1'b0);
    look(32'h40);
    checks++; if (lookup_taken !== 1'b0 || lookup_target !== 32'h200) begin failures++;
      $display("FAIL ctr_from_zero got=%b %h exp=0 200", lookup_taken, lookup_target); end
    do_upd(32'h40, 4'd0, 1'b1, 32'h200, 1'b0);
    look(32'h40);
    checks++; if (lookup_taken !== 1'b1) begin failures++;
      $display("FAIL ctr_to_two got=%b exp=1", lookup_taken); end
    repeat (2) do_upd(32'h40, 4'd0, 1'b1, 32'h200, 1'b0);
    look(32'h40);
    checks++; if (lookup_taken !== 1'b1) begin failures++;
      $display("FAIL ctr_ceiling got=%b exp=1", lookup_taken); end
    do_upd(32'h40, 4'd0, 1'b0, 32'h0, 1'b0);
    look(32'h40);
    checks++; if (lookup_taken !== 1'b1 || hit_cnt !== 32'd9) begin failures++;
      $display("FAIL ctr_three_down got taken=%b hit_cnt=%0d exp=1 9", lookup_taken, hit_cnt); end
  endtask

  task automatic test_replace;
    do_upd(32'h440, 4'd0, 1'b1, 32'h300, 1'b1);
    look(32'h40);
    checks++; if ({lookup_hit, lookup_taken} !== 2'b00 || lookup_target !== 32'd0) begin
      failures++;
      $display("FAIL replace_old_miss got=%b%b %h exp=00 0", lookup_hit, lookup_taken, lookup_target); end
    look(32'h440);
    checks++; if ({lookup_hit, lookup_taken} !== 2'b11 || lookup_target !== 32'h300) begin
      failures++;
      $display("FAIL replace_new_hit got=%b%b %h exp=11 300", lookup_hit, lookup_taken, lookup_target); end
    checks++; if (hit_cnt !== 32'd9 || mispred_cnt !== 32'd2) begin failures++;
      $display("FAIL replace_stats got=%0d/%0d exp=9/2", hit_cnt, mispred_cnt); end
    do_upd(32'h80, 4'd0, 1'b0, 32'h0, 1'b0);
    look(32'h440);
    checks++; if ({lookup_hit, lookup_taken} !== 2'b11 || hit_cnt !== 32'd9) begin failures++;
      $display("FAIL nt_miss_nochange got=%b%b cnt=%0d exp=11 9", lookup_hit, lookup_taken, hit_cnt); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    lookup_pc = 32'h44;
    upd_pc = 32'h44; upd_idx = 4'd1; upd_taken = 1'b1;
    upd_target = 32'h500; upd_valid = 1'b1;
    #1;
    checks++; if (lookup_hit !== 1'b0 || lookup_idx !== 4'd1) begin failures++;
      $display("FAIL rbw_pre got hit=%b idx=%0d exp=0 1", lookup_hit, lookup_idx); end
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    checks++; if (lookup_hit !== 1'b1 || lookup_target !== 32'h500) begin failures++;
      $display("FAIL rbw_post got=%b %h exp=1 500", lookup_hit, lookup_target); end
  endtask

  task automatic test_inv;
    @(negedge clk);
    inv_all = 1'b1;
    lookup_pc = 32'h440;
    upd_pc = 32'h44; upd_idx = 4'd1; upd_taken = 1'b1;
    upd_target = 32'h600; upd_mispredict = 1'b1;
    @(negedge clk);
    inv_all = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      checks++; if (ready !== 1'b0 || lookup_hit !== 1'b0) begin failures++;
        $display("FAIL inv_cycle%0d ready=%b hit=%b exp=0,0", k, ready, lookup_hit); end
      upd_valid = (k == 3);
      @(negedge clk);
    end
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    checks++; if (ready !== 1'b1) begin failures++;
      $display("FAIL inv_ready_rise got=%b exp=1", ready); end
    look(32'h440);
    checks++; if (lookup_hit !== 1'b0) begin failures++;
      $display("FAIL inv_miss_440 got=%b exp=0", lookup_hit); end
    look(32'h44);
    checks++; if (lookup_hit !== 1'b0) begin failures++;
      $display("FAIL inv_miss_44 got=%b exp=0", lookup_hit); end
    checks++; if (hit_cnt !== 32'd9 || mispred_cnt !== 32'd2) begin failures++;
      $display("FAIL inv_stats got=%0d/%0d exp=9/2", hit_cnt, mispred_cnt); end
  endtask

  task automatic test_gshare;
    logic [2:0] outc;
    logic [3:0] exp_idx [3];
    outc = 3'b101;
    exp_idx[0] = 4'h1; exp_idx[1] = 4'h2; exp_idx[2] = 4'h5;
    g_lookup_pc = 32'h40;
    #1;
    checks++; if (g_idx !== 4'h0) begin failures++;
      $display("FAIL gshare_idx0 got=%h exp=0", g_idx); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      g_upd_taken = outc[2-i];
      g_upd_valid = 1'b1;
      @(negedge clk);
      g_upd_valid = 1'b0;
      #1;
      checks++; if (g_idx !== exp_idx[i]) begin failures++;
        $display("FAIL gshare_idx_step%0d got=%h exp=%h", i, g_idx, exp_idx[i]); end
    end
    look(32'h40);
    checks++; if (lookup_idx !== 4'h0) begin failures++;
      $display("FAIL bimodal_idx_held got=%h exp=0", lookup_idx); end
  endtask

  initial begin
    test_reset("reset");
    test_alloc();
    test_counter();
    test_replace();
    test_back_to_back();
    test_inv();
    test_gshare();
    test_reset("reset_mid");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
